// File: rtl/cpu_pkg.sv
// Shared definitions for the 20-bit Dosage CPU: widths, opcodes and the fetch queue payload.
package cpu_pkg;

  localparam int unsigned IW    = 20;
  localparam int unsigned PCW   = 16;
  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP = 4'h0,
    OPC_ADD = 4'h1,
    OPC_SUB = 4'h2,
    OPC_AND = 4'h3,
    OPC_OR  = 4'h4,
    OPC_LD  = 4'h5,
    OPC_ST  = 4'h6,
    OPC_BEQ = 4'h7,
    OPC_JMP = 4'h8
  } opcode_e;

  localparam logic [IW-1:0] NOP = 20'h0;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
  } fetch_entry_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [IW-1:0] instr);
    return instr[IW-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of {pc, instr} with synchronous clear and occupancy count.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count
);

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  // Clear wins over push/pop; a push into a full queue is only legal with a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, imem request issue, epoch-tagged response capture and decode handshake.
// Optional FETCH_PERF_EN adds saturating delivered/flush counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned    QDEPTH   = 2,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_rdata,
  input  logic           br_taken,
  input  logic [PCW-1:0] br_pc,
  input  logic [15:0]    br_offset,
  output logic           inst_valid,
  input  logic           inst_ready,
  output logic [IW-1:0]  inst_out,
  output logic [PCW-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]    perf_fetched,
  output logic [15:0]    perf_flushes
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [PCW-1:0] pc;
  logic           epoch;
  logic           inflight;
  logic           inflight_epoch;
  logic [PCW-1:0] inflight_pc;
  logic [CW-1:0]  count;
  fetch_entry_t   head;
  fetch_entry_t   wr_entry;
  logic           deq_c;
  logic           enq_c;
  logic           issue_c;
  logic [CW:0]    pending_c;
  logic [PCW-1:0] target_c;

  assign deq_c     = inst_valid & inst_ready;
  // A same-cycle dequeue frees a slot for the response that lands next cycle.
  assign pending_c = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(deq_c);
  assign issue_c   = rst_n & ~br_taken & (pending_c < (CW+1)'(QDEPTH));
  assign enq_c     = inflight & (inflight_epoch == epoch) & ~br_taken;
  assign target_c  = br_pc + PCW'(1) + PCW'(br_offset);

  assign wr_entry.pc    = inflight_pc;
  assign wr_entry.instr = imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      inflight       <= issue_c;
      inflight_epoch <= epoch;
      inflight_pc    <= pc;
      if (br_taken) begin
        pc    <= target_c;
        epoch <= ~epoch;
      end else if (issue_c) begin
        pc <= pc + PCW'(1);
      end
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (br_taken),
    .wr_en   (enq_c),
    .wr_data (wr_entry),
    .rd_en   (deq_c),
    .rd_data (head),
    .count   (count)
  );

  assign imem_req   = issue_c;
  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst_out   = head.instr;
  assign inst_pc    = head.pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (deq_c && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (br_taken && perf_flushes != 16'hFFFF) perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized ready/branch traffic against a PC-stream model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_rdata = '0;
  logic           br_taken = 1'b0;
  logic [PCW-1:0] br_pc = '0;
  logic [15:0]    br_offset = '0;
  logic           inst_valid;
  logic           inst_ready = 1'b0;
  logic [IW-1:0]  inst_out;
  logic [PCW-1:0] inst_pc;

  logic           imem_req_w;
  logic [PCW-1:0] imem_addr_w;
  logic [IW-1:0]  imem_rdata_w = '0;
  logic           inst_valid_w;
  logic [IW-1:0]  inst_out_w;
  logic [PCW-1:0] inst_pc_w;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_flushes, perf_fetched_w, perf_flushes_w;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.QDEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  instr_fetch_unit #(.QDEPTH(2), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .br_taken(1'b0), .br_pc(16'h0000), .br_offset(16'h0000),
    .inst_valid(inst_valid_w), .inst_ready(1'b1), .inst_out(inst_out_w), .inst_pc(inst_pc_w)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched_w), .perf_flushes(perf_flushes_w)
`endif
  );

  // Instruction memory content is a function of the address so every word is self-identifying.
  function automatic logic [IW-1:0] imem_word(input logic [PCW-1:0] a);
    return {a[3:0] ^ 4'h9, a};
  endfunction

  always @(posedge clk) begin
    imem_rdata   <= imem_word(imem_addr);
    imem_rdata_w <= imem_word(imem_addr_w);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the consumer must see the PC stream since the last reset/redirect, in order.
  logic [PCW-1:0] exp_pc = '0;
  logic           prev_stall = 1'b0;
  logic           prev_br = 1'b0;
  int             delivered = 0;
  int             flushes = 0;

  task automatic cyc(input logic rdy, input logic br, input logic [PCW-1:0] bpc, input logic [15:0] off);
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = rdy;
    br_taken = br;
    br_pc = bpc;
    br_offset = off;
    #1;
    if (prev_br) chk("valid_after_flush", inst_valid, 0);
    if (prev_stall) chk("hold_valid", inst_valid, 1);
    if (br) chk("no_issue_on_br", imem_req, 0);
    if (inst_valid) begin
      chk("head_pc", inst_pc, exp_pc);
      chk("head_instr", inst_out, imem_word(exp_pc));
    end
    if (inst_valid && rdy) begin
      exp_pc = exp_pc + 16'd1;
      delivered++;
    end
    if (br) begin
      exp_pc = bpc + 16'd1 + off;
      flushes++;
    end
    prev_stall = inst_valid && !rdy && !br;
    prev_br = br;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_out"}, inst_out, 0);
    chk({tag, "_pc"}, inst_pc, 0);
    chk({tag, "_addr_w"}, imem_addr_w, 16'hFFFE);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_f"}, perf_fetched, 0);
    chk({tag, "_perf_b"}, perf_flushes, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inst_ready = 1'b0;
    br_taken = 1'b0;
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    exp_pc = 16'h0000;
    prev_stall = 1'b0;
    prev_br = 1'b0;
    delivered = 0;
    flushes = 0;
  endtask

  int reqs;
  bit seen;

  initial begin
    // Reset release and steady-state streaming; wrap instance runs alongside.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, '0, '0);
      if (k == 0) begin
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 16'h0000);
      end
      chk($sformatf("lat_valid_c%0d", k), inst_valid, (k >= 2) ? 1 : 0);
      chk($sformatf("wrap_valid_c%0d", k), inst_valid_w, (k >= 2) ? 1 : 0);
      if (k >= 2 && k <= 4) chk($sformatf("wrap_pc_c%0d", k), inst_pc_w, 16'(32'hFFFE + k - 2));
    end
    chk("stream_count", delivered, 6);

    // Stall from reset: exactly QDEPTH requests, head held at pc 0.
    do_reset();
    reqs = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, '0, '0);
      reqs += int'(imem_req);
    end
    chk("stall_reqs", reqs, 2);
    chk("stall_req_off", imem_req, 0);
    chk("stall_pc", inst_pc, 16'h0000);

    // Redirect with a negative offset while a response is in flight.
    repeat (3) cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 16'h0010, 16'hFFFC);
    cyc(1'b1, 1'b0, '0, '0);
    chk("br_addr", imem_addr, 16'h000D);
    chk("br_req", imem_req, 1);
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      cyc(1'b1, 1'b0, '0, '0);
      if (inst_valid) begin
        seen = 1;
        chk("br_first_pc", inst_pc, 16'h000D);
      end
    end
    chk("br_target_seen", seen, 1);

    // Branch in the same cycle as a handshake: delivered, then flushed.
    cyc(1'b1, 1'b0, '0, '0);
    chk("valid_at_br", inst_valid, 1);
    cyc(1'b1, 1'b1, 16'h0100, 16'h0020);
    cyc(1'b1, 1'b0, '0, '0);
    chk("br_hs_addr", imem_addr, 16'h0121);

    // Asynchronous reset in the middle of a stream.
    repeat (4) cyc(1'b1, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    @(negedge clk);
    exp_pc = 16'h0000;
    prev_stall = 1'b0;
    prev_br = 1'b0;
    delivered = 0;
    flushes = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, '0, '0);
      chk($sformatf("restart_valid_c%0d", k), inst_valid, (k >= 2) ? 1 : 0);
    end

    // Randomized ready/branch traffic.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          PCW'($urandom), 16'($urandom));
    end
    chk("random_progress", delivered > 150, 1);
`ifdef FETCH_PERF_EN
    cyc(1'b0, 1'b0, '0, '0);
    chk("perf_fetched", perf_fetched, delivered);
    chk("perf_flushes", perf_flushes, flushes);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
